// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (count, words, checksum) into IMEM writes.
// Latency: one word written per 5 cycles (4 byte cycles + 1 WRITE cycle); status the edge after the last checksum byte.
// Backpressure: byte_ready_o drops in WRITE, DONE, ERR and IDLE; unaccepted bytes stay with the sender.

package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module imem_loader
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            byte_ready_o,
    output logic            imem_we_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] imem_wdata_o,
    output logic            core_rst_no,
    output logic            done_o,
    output logic            error_o
);

    // One spare bit so that a count equal to DEPTH is representable.
    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;

    // Byte position inside the current 4-byte field.
    logic [1:0]        r_bcnt;
    // The three earlier bytes of the field; the 4th byte comes straight from the input.
    logic [23:0]       r_shift;
    // Word count from the header and index of the next word to write.
    logic [IW-1:0]     r_n;
    logic [IW-1:0]     r_idx;
    logic [XLEN-1:0]   r_xor;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;

    logic              w_ready;
    logic              w_fire;
    logic              w_last_byte;
    logic              w_start_ok;
    logic [XLEN-1:0]   w_word;
    logic              w_hdr_bad;
    logic [IW-1:0]     w_idx_inc;
    logic              w_last_word;

    // Handshake and field-assembly helpers.
    always_comb begin
        w_ready     = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CHK);
        w_fire      = w_ready && byte_valid_i;
        w_last_byte = w_fire && (r_bcnt == 2'd3);
        // start_i only has an effect in the resting states.
        w_start_ok  = start_i &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
        // Little-endian: the first byte received lands in bits [7:0].
        w_word      = {byte_data_i, r_shift};
        w_hdr_bad   = (w_word == '0) || (w_word > XLEN'(DEPTH));
        w_idx_inc   = r_idx + IW'(1);
        w_last_word = (w_idx_inc == r_n);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_last_byte) begin
                    w_next = w_hdr_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_word ? S_CHK : S_LOAD;
            end
            S_CHK: begin
                if (w_last_byte) begin
                    w_next = (w_word == r_xor) ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: byte assembly, header capture, write staging, checksum and index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bcnt  <= '0;
            r_shift <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_xor   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start_ok) begin
            // A new session never inherits a partial field or a stale checksum.
            r_bcnt  <= '0;
            r_shift <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_xor   <= '0;
        end else begin
            if (w_fire) begin
                r_bcnt  <= r_bcnt + 2'd1;
                r_shift <= {byte_data_i, r_shift[23:8]};
            end
            // A rejected header goes to ERR, so the truncated value is only kept when it fits.
            if ((r_state == S_HDR) && w_last_byte) begin
                r_n <= w_word[IW-1:0];
            end
            // Stage the write one edge early so address/data are stable for the whole WRITE cycle
            // and simply hold afterwards.
            if ((r_state == S_LOAD) && w_last_byte) begin
                r_addr  <= XLEN'(r_idx) << 2;
                r_wdata <= w_word;
            end
            if (r_state == S_WRITE) begin
                r_xor <= r_xor ^ r_wdata;
                r_idx <= w_idx_inc;
            end
        end
    end

    // Outputs decoded from state; reset puts the FSM in IDLE so all strobes fall at once.
    always_comb begin
        byte_ready_o = w_ready;
        imem_we_o    = (r_state == S_WRITE);
        imem_addr_o  = r_addr;
        imem_wdata_o = r_wdata;
        core_rst_no  = (r_state == S_DONE);
        done_o       = (r_state == S_DONE);
        error_o      = (r_state == S_ERR);
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bv;
    logic [7:0]  bd;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .byte_valid_i (bv),
        .byte_data_i  (bd),
        .byte_ready_o (byte_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .core_rst_no  (core_rst_n),
        .done_o       (done),
        .error_o      (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory image and write log observed on the IMEM port.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] tb_mem[DEPTH];
    logic [31:0] saved_mem[DEPTH];

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            if ((imem_addr >> 2) < DEPTH) tb_mem[imem_addr >> 2] = imem_wdata;
            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
    end

    // Payload of the stream currently being sent.
    logic [31:0] s_words[$];

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'd0;
    endtask

    // Present one byte and return right after the edge that accepted it.
    // Valid is left high so the next byte follows back-to-back (and stays up through WRITE).
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
                bv = 1'b0;
                bd = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bv = 1'b1;
        bd = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            check("byte_timeout", 32'd0, 32'd1);
            bv = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_stream(input logic [31:0] cks, input bit gaps);
        int t0;
        clear_log();
        do_start();
        t0 = cyc;
        send_word(32'(s_words.size()), gaps);
        foreach (s_words[i]) send_word(s_words[i], gaps);
        send_word(cks, gaps);
        bv = 1'b0;
        if (!gaps) check("throughput_cycles", 32'(cyc - t0), 32'(8 + 5 * s_words.size()));
    endtask

    // Reference: word i goes to byte address 4*i; success iff checksum equals XOR of all words.
    task automatic check_result(input string tag, input logic [31:0] cks);
        logic [31:0] xr;
        bit ok;
        xr = 32'd0;
        foreach (s_words[i]) xr ^= s_words[i];
        ok = (cks == xr);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(s_words.size()));
        foreach (s_words[i]) begin
            if (i < wr_addr_q.size()) begin
                check({tag, "_addr"}, wr_addr_q[i], 32'(i * 4));
                check({tag, "_data"}, wr_data_q[i], s_words[i]);
            end
        end
        check({tag, "_done"},     {31'd0, done},       {31'd0, ok});
        check({tag, "_error"},    {31'd0, error},      {31'd0, !ok});
        check({tag, "_core_rst"}, {31'd0, core_rst_n}, {31'd0, ok});
    endtask

    task automatic hdr_err(input string tag, input logic [31:0] n);
        clear_log();
        do_start();
        send_word(n, 1'b0);
        bv = 1'b0;
        check({tag, "_error"},    {31'd0, error},      32'd1);
        check({tag, "_done"},     {31'd0, done},       32'd0);
        check({tag, "_core_rst"}, {31'd0, core_rst_n}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    {31'd0, byte_ready}, 32'd0);
        check({tag, "_we"},       {31'd0, imem_we},    32'd0);
        check({tag, "_addr"},     imem_addr,           32'd0);
        check({tag, "_wdata"},    imem_wdata,          32'd0);
        check({tag, "_core_rst"}, {31'd0, core_rst_n}, 32'd0);
        check({tag, "_done"},     {31'd0, done},       32'd0);
        check({tag, "_error"},    {31'd0, error},      32'd0);
    endtask

    task automatic rand_words(input int n);
        s_words.delete();
        for (int i = 0; i < n; i++) s_words.push_back($urandom);
    endtask

    function automatic logic [31:0] xor_all();
        logic [31:0] x;
        x = 32'd0;
        foreach (s_words[i]) x ^= s_words[i];
        return x;
    endfunction

    initial begin
        int n;
        int diffs;
        logic [31:0] cks;
        bit gaps;

        rst_n = 1'b0;
        start = 1'b0;
        bv    = 1'b0;
        bd    = 8'd0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset_ready", {31'd0, byte_ready}, 32'd0);

        // Directed two-word program, good checksum.
        s_words = '{32'h0000_0013, 32'h0010_0093};
        run_stream(32'h0010_0080, 1'b0);
        check_result("two_words_ok", 32'h0010_0080);

        // Same payload with a zero checksum.
        s_words = '{32'h0000_0013, 32'h0010_0093};
        run_stream(32'h0000_0000, 1'b0);
        check_result("two_words_badck", 32'h0000_0000);

        // Rejected headers.
        hdr_err("hdr_zero", 32'd0);
        hdr_err("hdr_big", 32'(DEPTH + 1));

        // Same image with and without valid gaps must land identically.
        rand_words(7);
        cks = xor_all();
        run_stream(cks, 1'b0);
        check_result("nogap", cks);
        for (int i = 0; i < DEPTH; i++) saved_mem[i] = tb_mem[i];
        run_stream(cks, 1'b1);
        check_result("gap", cks);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== saved_mem[i]) diffs++;
        check("gap_mem_eq", 32'(diffs), 32'd0);

        // Reset in the middle of the payload.
        rand_words(3);
        clear_log();
        do_start();
        send_word(32'd3, 1'b0);
        send_word(s_words[0], 1'b0);
        send_byte(s_words[1][7:0], 1'b0);
        send_byte(s_words[1][15:8], 1'b0);
        bv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        check("midreset_nwrites", 32'(wr_addr_q.size()), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_words(4);
        cks = xor_all();
        run_stream(cks, 1'b0);
        check_result("after_reset", cks);

        // Randomized sessions against the reference.
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, DEPTH);
            rand_words(n);
            cks = xor_all();
            if ($urandom_range(0, 2) == 0) cks ^= 32'(1 << $urandom_range(0, 31));
            gaps = 1'($urandom_range(0, 1));
            run_stream(cks, gaps);
            check_result("random", cks);
        end

        // Full-capacity load, then a restart drops the core back into reset.
        rand_words(DEPTH);
        cks = xor_all();
        run_stream(cks, 1'b1);
        check_result("full_depth", cks);
        if (wr_addr_q.size() > 0)
            check("full_depth_last_addr", wr_addr_q[wr_addr_q.size() - 1], 32'((DEPTH - 1) * 4));
        do_start();
        check("restart_core_rst", {31'd0, core_rst_n}, 32'd0);
        check("restart_done",     {31'd0, done},       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2048, giving the instruction memory capacity in 32-bit words.
REQ-002 The block SHALL take XLEN (32) from riscv_pkg for all address and data widths.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  single-cycle request to begin a load session.
REQ-006 byte_valid_i  input  1  byte stream valid.
REQ-007 byte_data_i  input  8  byte stream data.
REQ-008 byte_ready_o  output  1  byte stream ready; a byte transfers when valid and ready are both high.
REQ-009 imem_we_o  output  1  instruction memory word write strobe.
REQ-010 imem_addr_o  output  XLEN  byte address of the write, word aligned (bits [1:0] = 0).
REQ-011 imem_wdata_o  output  XLEN  write data word.
REQ-012 core_rst_no  output  1  active-low hold-in-reset for the core; high only in DONE.
REQ-013 done_o  output  1  load completed and checksum matched.
REQ-014 error_o  output  1  load rejected (bad length or checksum mismatch).

Function
REQ-015 Stream format SHALL be: 4-byte word count N, then N data words, then a 4-byte checksum; every field is little-endian (first byte = bits [7:0]).
REQ-016 FSM states SHALL be IDLE, HDR, LOAD, WRITE, CHK, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start_i=1 -> HDR; clear byte counter, word index, running XOR, done_o and error_o; core_rst_no goes low in the same edge.
REQ-018 start_i SHALL be ignored in HDR, LOAD, WRITE and CHK.
REQ-019 byte_ready_o SHALL be 1 only in HDR, LOAD and CHK, and 0 in all other states.
REQ-020 HDR: after the 4th accepted byte, N==0 or N>DEPTH -> ERR; otherwise -> LOAD.
REQ-021 LOAD: on the 4th accepted byte of a word, the next state SHALL be WRITE.
REQ-022 WRITE SHALL last exactly one cycle with imem_we_o=1, imem_addr_o=idx*4 and imem_wdata_o=the assembled word.
REQ-023 In WRITE, the running XOR SHALL be updated with the assembled word and idx SHALL be incremented.
REQ-024 WRITE exit: idx+1==N -> CHK; otherwise -> LOAD.
REQ-025 imem_we_o SHALL be 0 in every state other than WRITE.
REQ-026 imem_addr_o and imem_wdata_o SHALL hold their last values outside WRITE.
REQ-027 CHK: after the 4th accepted byte, checksum==running XOR -> DONE; otherwise -> ERR.
REQ-028 DONE SHALL drive done_o=1 and core_rst_no=1.
REQ-029 ERR SHALL drive error_o=1 and core_rst_no=0.
REQ-030 Bytes presented while byte_ready_o=0 SHALL NOT be consumed.
REQ-031 Gaps in byte_valid_i SHALL stall assembly without loss or duplication.
REQ-032 Sustained throughput SHALL be one word per 5 cycles (4 byte cycles plus 1 WRITE cycle).
REQ-033 Word index width SHALL be $clog2(DEPTH)+1 bits; with N==DEPTH the final write goes to address (DEPTH-1)*4 with no wrap.
REQ-034 Partial byte counts SHALL NOT carry across a new start_i.

Reset
REQ-035 On rst_ni=0, the block SHALL asynchronously enter IDLE.
REQ-036 In reset, outputs SHALL be: byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, core_rst_no=0, done_o=0, error_o=0.
REQ-037 In reset, all counters and the running XOR SHALL be 0.
REQ-038 Reset asserted mid-load SHALL abort immediately; no further write strobes follow, and memory contents already written are left as is.
REQ-039 After reset deassertion, the block SHALL remain in IDLE until start_i.

Verification
REQ-040 Bench SHALL cover: start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, 80 00 10 00 -> two writes (addr 0x0 = 0x00000013, addr 0x4 = 0x00100093), then done_o=1 and core_rst_no=1.
REQ-041 Bench SHALL cover: same stream but checksum 00 00 00 00 -> both writes occur, then error_o=1, core_rst_no=0, done_o=0.
REQ-042 Bench SHALL cover: header 00 00 00 00, and separately header N=DEPTH+1 -> ERR right after the 4th byte, with no imem_we_o pulse.
REQ-043 Bench SHALL cover: random byte_valid_i gaps plus byte_valid_i held high during WRITE -> memory contents identical to the no-gap run, and byte_ready_o=0 in the WRITE cycle.
REQ-044 Bench SHALL cover: rst_ni low after 6 payload bytes -> all outputs at reset values immediately; a later start and a full stream load correctly from addr 0.
REQ-045 Bench SHALL cover: N=DEPTH full load -> last write at addr (DEPTH-1)*4, then done_o=1; a second start_i then drops core_rst_no the next cycle.
